branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/ariane_pkg.sv | 33 +++
 rtl/riscv_pkg.sv | 4 +
 rtl/br_resolve_lane.sv | 57 +++++
 rtl/branch_resolve_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Branch request/result types shared by the branch resolve unit and its lanes.
package ariane_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JAL  = 2'd1,
    BR_JALR = 2'd2
  } br_op_e;

  typedef struct packed {
    logic                     valid;
    br_op_e                   op;
    logic [riscv::VLEN-1:0]   pc;
    logic                     is_compressed;
    logic [riscv::VLEN-1:0]   operand_a;
    logic [riscv::VLEN-1:0]   imm;
    logic                     comp_res;
    logic                     pred_taken;
    logic [riscv::VLEN-1:0]   pred_addr;
    logic                     is_return;
  } br_req_t;

  typedef struct packed {
    logic [riscv::VLEN-1:0]   pc;
    logic [riscv::VLEN-1:0]   target;
    logic                     taken;
    logic                     is_mispredict;
    logic                     conditional;
    logic                     to_reg;
    logic                     exc_valid;
  } br_res_t;

endpackage

// File: rtl/riscv_pkg.sv
// Architectural constants used to size addresses throughout the core.
package riscv;
  localparam int unsigned VLEN = 32;
endpackage

// File: rtl/br_resolve_lane.sv
// Single-lane combinational branch resolver: target, link address,
// taken/mispredict decision and misaligned-target exception.
module br_resolve_lane
  import ariane_pkg::*;
#(
  parameter bit RVC = 1'b1
) (
  input  br_req_t                 req_i,
  output br_res_t                 res_o,
  output logic [riscv::VLEN-1:0]  next_pc_o
);

  logic [riscv::VLEN-1:0] npc;
  logic [riscv::VLEN-1:0] base;
  logic [riscv::VLEN-1:0] tgt;
  logic                   misaligned;
  logic                   misp;

  // Resolve one request; idle lanes never report a mispredict or exception.
  always_comb begin
    npc  = req_i.pc + (req_i.is_compressed ? riscv::VLEN'(2) : riscv::VLEN'(4));
    base = (req_i.op == BR_JALR) ? req_i.operand_a : req_i.pc;
    tgt  = base + req_i.imm;
    if (req_i.op == BR_JALR) tgt[0] = 1'b0;

    if (RVC) misaligned = tgt[0];
    else     misaligned = |tgt[1:0];

    misp                = 1'b0;
    res_o               = '0;
    res_o.pc            = req_i.pc;
    res_o.target        = tgt;

    case (req_i.op)
      BR_COND: begin
        res_o.taken       = req_i.comp_res;
        res_o.target      = req_i.comp_res ? tgt : npc;
        res_o.conditional = 1'b1;
        misp              = req_i.comp_res != req_i.pred_taken;
      end
      BR_JAL: begin
        res_o.taken = 1'b1;
      end
      BR_JALR: begin
        res_o.taken  = 1'b1;
        misp         = !req_i.pred_taken || (tgt != req_i.pred_addr);
        res_o.to_reg = misp && !req_i.is_return;
      end
      default: ;
    endcase

    res_o.is_mispredict = misp && req_i.valid;
    res_o.exc_valid     = res_o.taken && misaligned && req_i.valid;
    next_pc_o           = npc;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Multi-port branch resolve unit: one register stage of resolved lanes,
// kill of lanes younger than the first mispredict/exception, an in-order
// result queue and saturating statistics counters.
module branch_resolve_unit
  import ariane_pkg::*;
#(
  parameter int unsigned NR_PORTS   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          RVC        = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic                                  clear_cnt_i,
  input  br_req_t [NR_PORTS-1:0]                req_i,
  output logic                                  ready_o,
  output logic [NR_PORTS-1:0][riscv::VLEN-1:0]  link_o,
  output logic [NR_PORTS-1:0]                   link_valid_o,
  output br_res_t                               res_o,
  output logic                                  res_valid_o,
  input  logic                                  res_ready_i,
  output logic [CNT_W-1:0]                      br_cnt_o,
  output logic [CNT_W-1:0]                      misp_cnt_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int LC_W  = $clog2(NR_PORTS + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + 2 * NR_PORTS + 1) + 1;

  br_res_t [NR_PORTS-1:0]                lane_res;
  logic    [NR_PORTS-1:0][riscv::VLEN-1:0] lane_npc;

  br_res_t [NR_PORTS-1:0]                s1_res_q;
  logic    [NR_PORTS-1:0]                s1_valid_q;
  logic    [NR_PORTS-1:0][riscv::VLEN-1:0] link_q;

  br_res_t                               mem_q [FIFO_DEPTH];
  logic    [PTR_W-1:0]                   wptr_q, rptr_q;
  logic    [OCC_W-1:0]                   occ_q;
  logic    [CNT_W-1:0]                   br_cnt_q, misp_cnt_q;

  logic    [NR_PORTS-1:0]                accept;
  logic    [LC_W-1:0]                    s1_cnt;
  logic    [SUM_W-1:0]                   demand;
  logic    [NR_PORTS-1:0]                wr_en;
  logic    [NR_PORTS-1:0][PTR_W-1:0]     wr_idx;
  logic    [LC_W-1:0]                    n_push, n_misp;
  logic                                  kill;
  logic                                  pop;

  for (genvar g = 0; g < NR_PORTS; g++) begin : g_lane
    br_resolve_lane #(.RVC(RVC)) u_lane (
      .req_i     (req_i[g]),
      .res_o     (lane_res[g]),
      .next_pc_o (lane_npc[g])
    );
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [LC_W-1:0]  b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Reserve room for everything already queued or in flight plus a full new group.
  always_comb begin
    s1_cnt = '0;
    for (int i = 0; i < NR_PORTS; i++) s1_cnt = s1_cnt + LC_W'(s1_valid_q[i]);
    demand  = SUM_W'(occ_q) + SUM_W'(s1_cnt) + SUM_W'(NR_PORTS);
    ready_o = demand <= SUM_W'(FIFO_DEPTH);
    for (int i = 0; i < NR_PORTS; i++) accept[i] = req_i[i].valid && ready_o && !flush_i;
  end

  // Push surviving stage-1 lanes in order; the first redirecting lane kills younger ones.
  always_comb begin
    kill   = 1'b0;
    n_push = '0;
    n_misp = '0;
    wr_en  = '0;
    wr_idx = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      if (!flush_i && s1_valid_q[i] && !kill) begin
        wr_en[i]  = 1'b1;
        wr_idx[i] = wptr_q + PTR_W'(n_push);
        n_push    = n_push + LC_W'(1);
        if (s1_res_q[i].is_mispredict) n_misp = n_misp + LC_W'(1);
        if (s1_res_q[i].is_mispredict || s1_res_q[i].exc_valid) kill = 1'b1;
      end
    end
    pop = res_valid_o && res_ready_i && !flush_i;
  end

  // Stage-1 registers and queue pointers; flush drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= '0;
      s1_res_q   <= '0;
      link_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
    end else if (flush_i) begin
      s1_valid_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_res_q   <= lane_res;
      link_q     <= lane_npc;
      wptr_q     <= wptr_q + PTR_W'(n_push);
      rptr_q     <= rptr_q + PTR_W'(pop);
      occ_q      <= occ_q + OCC_W'(n_push) - OCC_W'(pop);
    end
  end

  // Queue storage; stale slots are harmless because occupancy gates the output.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_PORTS; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= s1_res_q[i];
    end
  end

  // Saturating statistics counters; clear takes priority over a concurrent push.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_cnt_i) begin
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
    end else begin
      br_cnt_q   <= sat_add(br_cnt_q, n_push);
      misp_cnt_q <= sat_add(misp_cnt_q, n_misp);
    end
  end

  assign link_o       = link_q;
  assign link_valid_o = s1_valid_q;
  assign res_o        = mem_q[rptr_q];
  assign res_valid_o  = occ_q != '0;
  assign br_cnt_o     = br_cnt_q;
  assign misp_cnt_o   = misp_cnt_q;

endmodule
